// File: rtl/umi_tx_arbiter.sv
// -----------------------------------------------------------------------------
// umi_tx_arbiter
//
// This block is a round-robin arbiter. It merges NUM_SRC single-beat UMI request
// streams into one UMI transmit stream, so several on-FPGA agents can share one
// host-bound tx queue slot. The output stage is one register, and it can take a
// new beat in the same cycle that it drains, so it sustains 1 beat per cycle.
//
// Optional build macro: UMI_TX_ARBITER_STATS_EN
//   When this macro is defined, the block adds one 32-bit grant counter per
//   source, exposed on grant_count. It also adds the stats_clear input, a
//   synchronous clear that wins over an increment in the same cycle.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   in_data      per-source data,            source i at [i*DW +: DW]
//   in_srcaddr   per-source source address,  source i at [i*AW +: AW]
//   in_dstaddr   per-source dest address,    source i at [i*AW +: AW]
//   in_cmd       per-source command,         source i at [i*CW +: CW]
//   in_valid     per-source valid
//   in_ready     per-source ready (at most one bit high per cycle)
//   out_data     merged data to tx queue
//   out_srcaddr  merged source address
//   out_dstaddr  merged destination address
//   out_cmd      merged command
//   out_valid    merged valid
//   out_ready    tx queue ready
//   out_src      index of the source that produced the current output beat
//   grant_count  (stats build) per-source transfer counters, 32 bits each
//   stats_clear  (stats build) synchronous clear of all counters
// -----------------------------------------------------------------------------
module umi_tx_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DW      = 256,
    parameter int AW      = 64,
    parameter int CW      = 32,
    localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC*DW-1:0] in_data,
    input  logic [NUM_SRC*AW-1:0] in_srcaddr,
    input  logic [NUM_SRC*AW-1:0] in_dstaddr,
    input  logic [NUM_SRC*CW-1:0] in_cmd,
    input  logic [NUM_SRC-1:0]    in_valid,
    output logic [NUM_SRC-1:0]    in_ready,
    output logic [DW-1:0]         out_data,
    output logic [AW-1:0]         out_srcaddr,
    output logic [AW-1:0]         out_dstaddr,
    output logic [CW-1:0]         out_cmd,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef UMI_TX_ARBITER_STATS_EN
    output logic [NUM_SRC*32-1:0] grant_count,
    input  logic                  stats_clear,
`endif
    output logic [SW-1:0]         out_src
);

    logic [SW-1:0] ptr;
    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] ptr_nxt;
    logic          load_ok;
    logic          xfer;

    logic [DW-1:0] data_p1;
    logic [AW-1:0] srcaddr_p1;
    logic [AW-1:0] dstaddr_p1;
    logic [CW-1:0] cmd_p1;
    logic [SW-1:0] src_p1;
    logic          vld_p1;

    assign load_ok = !vld_p1 || out_ready;

    // Grant: scan from ptr upward, modulo NUM_SRC. The loop walks the scan
    // order backwards, so the first valid source in scan order is the last one
    // written and therefore wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            logic [SW:0] sum;
            sum = {1'b0, ptr} + (SW+1)'(k);
            if (sum >= (SW+1)'(NUM_SRC)) begin
                sum = sum - (SW+1)'(NUM_SRC);
            end
            if (in_valid[sum[SW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[SW-1:0];
            end
        end
    end

    // in_ready is held low while reset is asserted, because the register
    // cannot capture a beat then.
    assign xfer = gnt_vld && load_ok && !reset;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign ptr_nxt = (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    // ---- stage p1: output register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            srcaddr_p1 <= '0;
            dstaddr_p1 <= '0;
            cmd_p1     <= '0;
            src_p1     <= '0;
            ptr        <= '0;
        end else if (xfer) begin
            vld_p1     <= 1'b1;
            data_p1    <= in_data[int'(gnt_idx)*DW +: DW];
            srcaddr_p1 <= in_srcaddr[int'(gnt_idx)*AW +: AW];
            dstaddr_p1 <= in_dstaddr[int'(gnt_idx)*AW +: AW];
            cmd_p1     <= in_cmd[int'(gnt_idx)*CW +: CW];
            src_p1     <= gnt_idx;
            ptr        <= ptr_nxt;
        end else if (out_ready) begin
            // Drain with nothing to replace it: the fields keep their last value.
            vld_p1 <= 1'b0;
        end
    end

    assign out_data    = data_p1;
    assign out_srcaddr = srcaddr_p1;
    assign out_dstaddr = dstaddr_p1;
    assign out_cmd     = cmd_p1;
    assign out_src     = src_p1;
    assign out_valid   = vld_p1;

`ifdef UMI_TX_ARBITER_STATS_EN
    logic [31:0] cnt [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (stats_clear) begin
                cnt[i] <= '0;
            end else if (in_valid[i] && in_ready[i]) begin
                cnt[i] <= cnt[i] + 32'd1;
            end
        end
        assign grant_count[i*32 +: 32] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_umi_tx_arbiter.sv
module tb_umi_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // two-source instance
    logic [31:0] in_data;
    logic [15:0] in_srcaddr, in_dstaddr, in_cmd;
    logic [1:0]  in_valid, in_ready;
    logic [15:0] out_data;
    logic [7:0]  out_srcaddr, out_dstaddr, out_cmd;
    logic        out_valid, out_ready;
    logic        out_src;
`ifdef UMI_TX_ARBITER_STATS_EN
    logic [63:0] grant_count;
    logic        stats_clear;
`endif

    // three-source instance
    logic [47:0] in_data3;
    logic [23:0] in_srcaddr3, in_dstaddr3, in_cmd3;
    logic [2:0]  in_valid3, in_ready3;
    logic [15:0] out_data3;
    logic [7:0]  out_srcaddr3, out_dstaddr3, out_cmd3;
    logic        out_valid3, out_ready3;
    logic [1:0]  out_src3;
`ifdef UMI_TX_ARBITER_STATS_EN
    logic [95:0] grant_count3;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    umi_tx_arbiter #(.NUM_SRC(2), .DW(16), .AW(8), .CW(8)) dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_srcaddr(in_srcaddr), .in_dstaddr(in_dstaddr),
        .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_srcaddr(out_srcaddr), .out_dstaddr(out_dstaddr),
        .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
`ifdef UMI_TX_ARBITER_STATS_EN
        .grant_count(grant_count), .stats_clear(stats_clear),
`endif
        .out_src(out_src)
    );

    umi_tx_arbiter #(.NUM_SRC(3), .DW(16), .AW(8), .CW(8)) dut3 (
        .clk(clk), .reset(reset),
        .in_data(in_data3), .in_srcaddr(in_srcaddr3), .in_dstaddr(in_dstaddr3),
        .in_cmd(in_cmd3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_srcaddr(out_srcaddr3), .out_dstaddr(out_dstaddr3),
        .out_cmd(out_cmd3), .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef UMI_TX_ARBITER_STATS_EN
        .grant_count(grant_count3), .stats_clear(1'b0),
`endif
        .out_src(out_src3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] c0, c1, held, exp_cmd;
    int         exp_src;

    initial begin
        reset       = 1'b1;
        in_data     = '0;
        in_srcaddr  = '0;
        in_dstaddr  = '0;
        in_cmd      = '0;
        in_valid    = 2'b11;
        out_ready   = 1'b1;
        in_data3    = '0;
        in_srcaddr3 = '0;
        in_dstaddr3 = '0;
        in_cmd3     = '0;
        in_valid3   = '0;
        out_ready3  = 1'b1;
`ifdef UMI_TX_ARBITER_STATS_EN
        stats_clear = 1'b0;
`endif
        tick();
        tick();
        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_cmd", out_cmd, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        in_valid = 2'b00;
        reset    = 1'b0;
        tick();

        // only source 1 valid
        in_valid = 2'b10;
        in_cmd   = 16'h1100;
        in_data  = 32'hBEEF_0000;
        #1;
        check("t1_in_ready", in_ready, 2'b10);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_cmd", out_cmd, 8'h11);
        check("t1_out_src", out_src, 1);
        check("t1_out_data", out_data, 16'hBEEF);

        // both continuously valid: the pointer is 0, so grants alternate 0,1,...
        c0 = 8'h20;
        c1 = 8'h30;
        in_cmd   = {c1, c0};
        in_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            exp_src = i % 2;
            exp_cmd = (exp_src == 0) ? c0 : c1;
            #1;
            check("rr_in_ready", in_ready, 2'b01 << exp_src);
            tick();
            check("rr_out_valid", out_valid, 1);
            check("rr_out_src", out_src, exp_src);
            check("rr_out_cmd", out_cmd, exp_cmd);
            if (exp_src == 0) c0 = c0 + 8'd1; else c1 = c1 + 8'd1;
            in_cmd = {c1, c0};
        end

        // stall: the register holds the last src1 beat (0x33)
        held      = 8'h33;
        out_ready = 1'b0;
        #1;
        check("stall_in_ready0", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_out_cmd", out_cmd, held);
            check("stall_out_src", out_src, 1);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", in_ready, 2'b01);
        tick();
        check("unstall_out_valid", out_valid, 1);
        check("unstall_out_src", out_src, 0);
        check("unstall_out_cmd", out_cmd, 8'h24);

        // drain without a new beat; the fields keep their last value, ptr stays at 1
        in_valid = 2'b00;
        tick();
        check("drain_out_valid", out_valid, 0);
        check("drain_out_cmd", out_cmd, 8'h24);
        tick();
        in_valid = 2'b11;
        #1;
        check("idle_ptr_hold", in_ready, 2'b10);

        // reset while source 0 is stalled behind a full register
        in_valid = 2'b01;
        in_cmd   = 16'h0050;
        #1;
        tick();
        check("pre_rst_out_cmd", out_cmd, 8'h50);
        out_ready = 1'b0;
        in_cmd    = 16'h0051;
        #1;
        check("pre_rst_in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 2'b11;
        in_cmd    = 16'h6051;
        #1;
        check("post_rst_in_ready", in_ready, 2'b01);
        tick();
        check("post_rst_src", out_src, 0);
        check("post_rst_cmd", out_cmd, 8'h51);
        in_valid = 2'b10;
        #1;
        tick();
        check("post_rst_next_src", out_src, 1);
        check("post_rst_next_cmd", out_cmd, 8'h60);
        in_valid = 2'b00;
        tick();
        check("post_rst_empty", out_valid, 0);

`ifdef UMI_TX_ARBITER_STATS_EN
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        in_valid = 2'b01;
        tick(); tick(); tick();
        in_valid = 2'b10;
        tick(); tick();
        in_valid = 2'b00;
        check("stats_cnt0", grant_count[31:0], 3);
        check("stats_cnt1", grant_count[63:32], 2);
        in_valid    = 2'b01;
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        in_valid    = 2'b00;
        check("stats_clr0", grant_count[31:0], 0);
        check("stats_clr1", grant_count[63:32], 0);
        tick();
`endif

        // three sources, only 0 and 2 valid; the pointer wraps from 2 to 0
        in_valid3 = 3'b101;
        in_cmd3   = 24'h42_41_40;
        for (int i = 0; i < 4; i++) begin
            exp_src = (i % 2 == 0) ? 0 : 2;
            #1;
            check("n3_in_ready", in_ready3, 3'b001 << exp_src);
            tick();
            check("n3_out_valid", out_valid3, 1);
            check("n3_out_src", out_src3, exp_src);
            check("n3_out_cmd", out_cmd3, 8'h40 + exp_src);
        end
        in_valid3 = 3'b000;
        tick();
        check("n3_empty", out_valid3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/umi_tx_arbiter.md
Name: umi_tx_arbiter

Overview:
- Round-robin arbiter that merges NUM_SRC independent UMI request streams into one UMI transmit stream.
- The output drives a single tx queue slot (tx_data/tx_srcaddr/tx_dstaddr/tx_cmd/tx_valid/tx_ready) of the FPGA queue block, so several on-FPGA agents can share one host-bound queue.
- Single-beat UMI packets only.
- One registered output stage with full throughput.

Parameters:
- NUM_SRC, 2, number of input UMI streams (>=1).
- DW, 256, UMI data width.
- AW, 64, UMI address width.
- CW, 32, UMI command width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- in_data  input  NUM_SRC*DW  per-source data, source i at [i*DW+:DW].
- in_srcaddr  input  NUM_SRC*AW  per-source source address.
- in_dstaddr  input  NUM_SRC*AW  per-source destination address.
- in_cmd  input  NUM_SRC*CW  per-source command.
- in_valid  input  NUM_SRC  per-source valid.
- in_ready  output  NUM_SRC  per-source ready.
- out_data  output  DW  merged data to tx queue.
- out_srcaddr  output  AW  merged source address.
- out_dstaddr  output  AW  merged destination address.
- out_cmd  output  CW  merged command.
- out_valid  output  1  merged valid.
- out_ready  input  1  tx queue ready.
- out_src  output  $clog2(NUM_SRC) (min 1)  index of source that produced the current output beat.

Behaviour:
- Reset is asynchronous, active-high, one clock domain (clk).
  - While reset=1: out_valid=0, out_data/out_srcaddr/out_dstaddr/out_cmd=0, out_src=0, rr pointer=0.
  - in_ready=0 for all sources.
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- load_ok = !out_valid || out_ready. The register accepts a new beat whenever it is empty or draining this cycle.
- Grant is combinational:
  - Scan sources ptr, ptr+1, ..., ptr+NUM_SRC-1 (mod NUM_SRC).
  - The first source with in_valid=1 is granted.
  - No valid source: no grant.
- in_ready[g]=load_ok for the granted source g only. All other in_ready bits are 0.
  - At most one in_ready bit is high per cycle.
  - in_ready may depend combinationally on in_valid and out_ready.
- Transfer on source g occurs when in_valid[g] && in_ready[g].
  - On the next edge, out_* load source g's fields, out_src=g, out_valid=1.
  - ptr <= (g+1) mod NUM_SRC.
- When out_valid && out_ready and there is no new transfer: out_valid <= 0. Data fields hold their last value.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one. Zero bubble, sustained 1 beat/cycle.
- Latency: in-transfer cycle N produces out_valid in cycle N+1.
- out_valid && !out_ready: all out_* stay stable and all in_ready=0.
- The pointer only advances on a transfer. An idle cycle or a stall does not move priority.
- Wrap-around: a grant to NUM_SRC-1 sets ptr=0.
- NUM_SRC=1: degenerates to a pipeline register; ptr stays 0 and out_src=0.
- Fairness: with all sources continuously valid and out_ready=1, grants cycle 0,1,...,NUM_SRC-1,0,...
- No packet is dropped, duplicated or reordered within a source.
- Reset asserted mid-stream: the in-flight output beat is discarded and out_valid=0 asynchronously. After release, arbitration restarts at source 0.

Optional Feature:
- Macro: UMI_TX_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_count, width NUM_SRC*32: one 32-bit counter per source.
  - Counter i increments by 1 on each in-transfer from source i and wraps 0xFFFFFFFF -> 0.
  - Reset value is 0.
  - Adds input port stats_clear (1 bit): synchronous clear of all counters. Clear has priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is generated. Arbitration behaviour is identical in both builds.

Test Plan:
- NUM_SRC=2, only source 1 valid with cmd=0x11, out_ready=1 -> in_ready[1]=1 in the same cycle; next cycle out_valid=1, out_cmd=0x11, out_src=1; ptr=0.
- Both sources continuously valid, 8 cycles, out_ready=1 -> out_src sequence 0,1,0,1,0,1,0,1, one beat per cycle, no bubbles.
- Register FULL, out_ready=0 for 5 cycles with both sources valid -> out_* unchanged, in_ready=00 throughout; on the first out_ready=1 cycle the next granted beat loads with zero bubble.
- NUM_SRC=3, only sources 0 and 2 valid, 4 beats -> out_src 0,2,0,2; pointer wraps from 2 to 0.
- Assert reset while out_valid=1 and source 0 is stalled -> out_valid=0 immediately. After release, the first grant goes to source 0 and the stalled beat is re-presented by source 0 and delivered once.
- With UMI_TX_ARBITER_STATS_EN, 3 beats from src0 and 2 from src1, then stats_clear coincident with one more src0 beat -> counts 3 and 2 before the clear; after the clear cycle both counts are 0.
